// File: rtl/gcd_stein.sv
// gcd_stein: binary (Stein) GCD with val/rdy channels and a request tag carried to the result.
// Optional GCD_CYCLE_COUNT_EN adds the result_cycles port reporting CALC cycles used.
module gcd_stein #(
  parameter int W = 128,
  parameter int TAG_W = 4
`ifdef GCD_CYCLE_COUNT_EN
  , localparam int CNT_W = $clog2(2*W+2)
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     operands_bits_A,
  input  logic [W-1:0]     operands_bits_B,
  input  logic [TAG_W-1:0] operands_tag,
  input  logic             operands_val,
  output logic             operands_rdy,
  output logic [W-1:0]     result_bits_data,
  output logic [TAG_W-1:0] result_tag,
  output logic             result_val,
  input  logic             result_rdy
`ifdef GCD_CYCLE_COUNT_EN
  , output logic [CNT_W-1:0] result_cycles
`endif
);
  localparam int K_W = $clog2(W+1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state;
  logic [W-1:0] r_a, r_b, r_res;
  logic [K_W-1:0] r_k;
  logic [TAG_W-1:0] r_tag;
  logic r_rdy, r_val;
  logic w_a_ge_b;
  logic [W-1:0] w_diff;
`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_cnt, r_cycles;
  assign result_cycles = r_cycles;
`endif
  assign w_a_ge_b = r_a >= r_b;
  assign w_diff = w_a_ge_b ? r_a - r_b : r_b - r_a;
  assign operands_rdy = r_rdy;
  assign result_val = r_val;
  assign result_bits_data = r_res;
  assign result_tag = r_tag;
  // ready/valid are registered flags tracking the state, so reset can hold ready low while IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rdy <= 1'b0;
      r_val <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_k <= '0;
      r_res <= '0;
      r_tag <= '0;
`ifdef GCD_CYCLE_COUNT_EN
      r_cnt <= '0;
      r_cycles <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (operands_val && r_rdy) begin
            r_a <= operands_bits_A;
            r_b <= operands_bits_B;
            r_tag <= operands_tag;
            r_k <= '0;
`ifdef GCD_CYCLE_COUNT_EN
            r_cnt <= '0;
`endif
            r_rdy <= 1'b0;
            r_state <= CALC;
          end else begin
            r_rdy <= 1'b1;
          end
        end
        CALC: begin
`ifdef GCD_CYCLE_COUNT_EN
          r_cnt <= r_cnt + 1'b1;
`endif
          if (r_b == '0 || r_a == '0) begin
            r_res <= (r_b == '0 ? r_a : r_b) << r_k;
`ifdef GCD_CYCLE_COUNT_EN
            r_cycles <= r_cnt + 1'b1;
`endif
            r_val <= 1'b1;
            r_state <= DONE;
          end else if (!r_a[0] && !r_b[0]) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_k <= r_k + 1'b1;
          end else if (!r_a[0]) begin
            r_a <= r_a >> 1;
          end else if (!r_b[0]) begin
            r_b <= r_b >> 1;
          end else if (w_a_ge_b) begin
            r_a <= w_diff >> 1;
          end else begin
            r_b <= w_diff >> 1;
          end
        end
        DONE: begin
          if (result_rdy) begin
            r_val <= 1'b0;
            r_rdy <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_stein.sv
// tb_gcd_stein: directed vector table, multi-cycle corner sequences and random requests vs a Euclid model.
module tb_gcd_stein;
  localparam int W = 128;
  localparam int TAG_W = 4;
  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] op_a, op_b, res_data;
  logic [TAG_W-1:0] op_tag, res_tag;
  logic op_val, op_rdy, res_val, res_rdy;
`ifdef GCD_CYCLE_COUNT_EN
  logic [$clog2(2*W+2)-1:0] res_cycles;
`endif
  int checks = 0;
  int failures = 0;

  gcd_stein #(.W(W), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .reset(reset),
    .operands_bits_A(op_a),
    .operands_bits_B(op_b),
    .operands_tag(op_tag),
    .operands_val(op_val),
    .operands_rdy(op_rdy),
    .result_bits_data(res_data),
    .result_tag(res_tag),
    .result_val(res_val),
    .result_rdy(res_rdy)
`ifdef GCD_CYCLE_COUNT_EN
    , .result_cycles(res_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [TAG_W-1:0] tag;
    logic [W-1:0] exp;
    int cyc;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TAG_W-1:0] t,
                     input int bp, output logic [W-1:0] d, output logic [TAG_W-1:0] tg,
                     output int lat, output int cyc);
    int n;
    n = 0;
    while (!op_rdy && n < 50) begin
      tick();
      n++;
    end
    if (!op_rdy) chk("rdy_timeout", {127'd0, op_rdy}, 128'd1);
    op_a = a;
    op_b = b;
    op_tag = t;
    op_val = 1'b1;
    tick();
    op_val = 1'b0;
    lat = 1;
    while (!res_val && lat < 400) begin
      tick();
      lat++;
    end
    if (!res_val) chk("result_timeout", {127'd0, res_val}, 128'd1);
    repeat (bp) tick();
    d = res_data;
    tg = res_tag;
`ifdef GCD_CYCLE_COUNT_EN
    cyc = int'(res_cycles);
`else
    cyc = -1;
`endif
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
  endtask

  initial begin
    vec_t vecs[7];
    logic [W-1:0] d, hold_d, ra, rb;
    logic [TAG_W-1:0] tg, hold_tg, rt;
    int lat, cyc;
    vecs[0] = '{a: 128'd12, b: 128'd8, tag: 4'd3, exp: 128'd4, cyc: 6};
    vecs[1] = '{a: 128'd0, b: 128'd5, tag: 4'd1, exp: 128'd5, cyc: 1};
    vecs[2] = '{a: 128'd0, b: 128'd0, tag: 4'd2, exp: 128'd0, cyc: 1};
    vecs[3] = '{a: 128'd7, b: 128'd7, tag: 4'd5, exp: 128'd7, cyc: 2};
    vecs[4] = '{a: 128'd1 << 127, b: 128'd1 << 64, tag: 4'd6, exp: 128'd1 << 64, cyc: 129};
    vecs[5] = '{a: 128'd5, b: 128'd0, tag: 4'd7, exp: 128'd5, cyc: 1};
    vecs[6] = '{a: 128'd48, b: 128'd18, tag: 4'd9, exp: 128'd6, cyc: 7};

    reset = 1'b0;
    op_val = 1'b0;
    op_a = '0;
    op_b = '0;
    op_tag = '0;
    res_rdy = 1'b0;
    repeat (2) tick();
    chk("reset_rdy", {127'd0, op_rdy}, 128'd0);
    chk("reset_val", {127'd0, res_val}, 128'd0);
    chk("reset_data", res_data, 128'd0);
    chk("reset_tag", {124'd0, res_tag}, 128'd0);
`ifdef GCD_CYCLE_COUNT_EN
    chk("reset_cycles", {119'd0, res_cycles}, 128'd0);
`endif
    reset = 1'b1;
    tick();
    chk("rdy_after_release", {127'd0, op_rdy}, 128'd1);

    for (int i = 0; i < 7; i++) begin
      run(vecs[i].a, vecs[i].b, vecs[i].tag, 0, d, tg, lat, cyc);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
      chk($sformatf("vec%0d_tag", i), {124'd0, tg}, {124'd0, vecs[i].tag});
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].cyc + 1));
`ifdef GCD_CYCLE_COUNT_EN
      chk($sformatf("vec%0d_cycles", i), 128'(cyc), 128'(vecs[i].cyc));
`endif
    end

    // backpressure: hold result_rdy low in DONE while offering a competing request
    op_a = 128'd100;
    op_b = 128'd75;
    op_tag = 4'd4;
    op_val = 1'b1;
    tick();
    op_a = 128'd9;
    op_b = 128'd3;
    op_tag = 4'd11;
    lat = 0;
    while (!res_val && lat < 400) begin
      tick();
      lat++;
    end
    chk("bp_val", {127'd0, res_val}, 128'd1);
    hold_d = res_data;
    hold_tg = res_tag;
    chk("bp_data", hold_d, 128'd25);
    chk("bp_tag", {124'd0, hold_tg}, 128'd4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_val", {127'd0, res_val}, 128'd1);
      chk("bp_hold_data", res_data, 128'd25);
      chk("bp_hold_tag", {124'd0, res_tag}, 128'd4);
      chk("bp_hold_rdy", {127'd0, op_rdy}, 128'd0);
    end
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    op_val = 1'b0;
    chk("bp_release_val", {127'd0, res_val}, 128'd0);
    chk("bp_release_rdy", {127'd0, op_rdy}, 128'd1);
    repeat (40) tick();
    chk("bp_no_second_accept", {127'd0, res_val}, 128'd0);

    // reset mid-CALC aborts the request
    op_a = 128'd1000;
    op_b = 128'd999;
    op_tag = 4'd12;
    op_val = 1'b1;
    tick();
    op_val = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_val", {127'd0, res_val}, 128'd0);
    chk("abort_data", res_data, 128'd0);
    chk("abort_tag", {124'd0, res_tag}, 128'd0);
    chk("abort_rdy", {127'd0, op_rdy}, 128'd0);
`ifdef GCD_CYCLE_COUNT_EN
    chk("abort_cycles", {119'd0, res_cycles}, 128'd0);
`endif
    run(128'd9, 128'd6, 4'd13, 0, d, tg, lat, cyc);
    chk("post_abort_data", d, 128'd3);
    chk("post_abort_tag", {124'd0, tg}, 128'd13);

    for (int i = 0; i < 1000; i++) begin
      ra = 128'($urandom_range(0, 15) == 0 ? 0 : $urandom_range(0, 65535));
      rb = 128'($urandom_range(0, 15) == 0 ? 0 : $urandom_range(0, 65535));
      rt = 4'($urandom_range(0, 15));
      run(ra, rb, rt, int'($urandom_range(0, 3)), d, tg, lat, cyc);
      chk("rand_data", d, ref_gcd(ra, rb));
      chk("rand_tag", {124'd0, tg}, {124'd0, rt});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
